audio_decim_fifo: RTL and testbench
===================================

// Module: audio_decim_fifo
// PURPOSE
//   Downstream of the 128-sample DC-removal stage in the FM demodulator chain.
//   Takes its DC-free demodulated samples, qualified by a per-sample strobe, and
//   decimates them by 2**DECIM_LOG2 using boxcar accumulate-and-dump.
//   Buffers the decimated audio in a small FIFO behind a valid/ready output
//   handshake for the audio output stage. Flags results lost to back-pressure.
// PARAMETERS
//   WIDTH          16  sample width, signed two's complement, input and output
//   DECIM_LOG2     3   decimation factor = 2**DECIM_LOG2 (default 8); range 1..7
//   FIFO_AW        2   FIFO address width; depth = 2**FIFO_AW (default 4 entries)
// PORTS
//   clk          in   1            system clock, all logic on rising edge
//   rst_n        in   1            asynchronous reset, active low
//   sample_vld_i in   1            input strobe; 1 = data_i carries a new sample
//   data_i       in   WIDTH        signed DC-removed sample from averaging stage
//   clear_i      in   1            sync flush: empties FIFO, zeroes accumulator/count, clears overrun_o
//   data_o       out  WIDTH        signed decimated sample at FIFO head
//   valid_o      out  1            1 = data_o valid (FIFO not empty)
//   ready_i      in   1            consumer ready; pop when valid_o & ready_i
//   overrun_o    out  1            sticky: a decimated result was dropped (FIFO full)
//   level_o      out  FIFO_AW+1    number of entries currently in FIFO
// BEHAVIOUR
//   Reset (rst_n=0, async): accumulator=0, count=0, FIFO pointers=0, valid_o=0,
//     overrun_o=0, level_o=0. data_o=0: FIFO storage is cleared, head reads 0.
//   Accumulator: signed, WIDTH+DECIM_LOG2 bits, so it can never overflow.
//     count: DECIM_LOG2 bits, incremented on each sample_vld_i and wraps to 0.
//   Sample cycle with count < 2**DECIM_LOG2-1: acc <= acc + data_i; count++.
//   Sample cycle with count = 2**DECIM_LOG2-1 (dump):
//     result = (acc + data_i) >>> DECIM_LOG2, arithmetic shift, floor rounding.
//     result always fits WIDTH bits, so no saturation is needed.
//     acc <= 0; count <= 0; result is written into FIFO on the same edge.
//     valid_o/data_o reflect it 1 cycle after the dump strobe if FIFO was empty.
//   sample_vld_i=0: acc and count hold; data_i is ignored.
//   FIFO: first-word-fall-through. data_o = mem[rd_ptr]. valid_o = (level_o != 0).
//     Pointers are FIFO_AW+1 bits with a wrap bit; full = level_o == 2**FIFO_AW.
//   Pop happens when valid_o & ready_i. Pop with valid_o=0 is ignored.
//     data_o is stable while valid_o=1 and ready_i=0.
//   Push (dump) while not full: accepted.
//   Push while full, same cycle as a pop: pop frees a slot, push accepted,
//     level_o unchanged.
//   Push while full, no pop: result dropped, FIFO unchanged, overrun_o <= 1.
//     overrun_o stays 1 until clear_i or reset.
//   Push and pop on an empty FIFO: there is no bypass. Push is accepted and
//     valid_o rises next cycle.
//   clear_i=1 (sync, highest priority): any sample or pop in that cycle is
//     discarded. Next state equals the reset state.
//   Reset mid-accumulation discards the partial sum. The next dump occurs after
//     a full 2**DECIM_LOG2 fresh samples.
// TESTING (defaults: WIDTH=16, DECIM 8, depth 4)
//   1. 8 strobes of data_i=100, ready_i=1 -> one output: data_o=100, valid_o=1 one
//      cycle after the 8th strobe, level_o 1 then 0 after the pop.
//   2. data_i=1..8 -> 4 (36>>3). data_i=-1..-8 -> -5 (floor of -4.5).
//      8x(-1) -> -1.
//   3. 8x32767 -> 32767. 8x(-32768) -> -32768. No wrap in either case.
//   4. ready_i=0, 40 strobes (5 dumps) -> level_o=4, overrun_o=1 after the 5th
//      dump. Popping then yields results 1..4 in order; the 5th is absent.
//   5. FIFO full and ready_i=1 on the dump cycle -> push accepted, level_o stays
//      4, overrun_o stays 0.
//   6. 3 strobes, then rst_n pulsed low asynchronously mid-cycle -> outputs 0
//      immediately. The next output needs 8 new strobes. Repeat with clear_i:
//      same result.

Source files
------------

// File: rtl/audio_decim_fifo.sv
// Boxcar decimator (accumulate-and-dump by 2**DECIM_LOG2) feeding a small
// first-word-fall-through FIFO with valid/ready output and sticky overrun flag.
module audio_decim_fifo #(
   parameter int WIDTH      = 16,
   parameter int DECIM_LOG2 = 3,
   parameter int FIFO_AW    = 2
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               sample_vld_i,
   input  logic [WIDTH-1:0]   data_i,
   input  logic               clear_i,
   output logic [WIDTH-1:0]   data_o,
   output logic               valid_o,
   input  logic               ready_i,
   output logic               overrun_o,
   output logic [FIFO_AW:0]   level_o
);

   localparam int ACC_W = WIDTH + DECIM_LOG2;
   localparam int DEPTH = 1 << FIFO_AW;
   localparam logic [FIFO_AW:0] FULL_LEVEL = (FIFO_AW + 1)'(DEPTH);

   logic signed [ACC_W-1:0] acc_reg, acc_next;
   logic [DECIM_LOG2-1:0]   cnt_reg, cnt_next;
   logic [FIFO_AW:0]        wr_ptr_reg, wr_ptr_next;
   logic [FIFO_AW:0]        rd_ptr_reg, rd_ptr_next;
   logic                    overrun_reg, overrun_next;
   logic [WIDTH-1:0]        mem_reg [DEPTH];

   logic signed [ACC_W-1:0] data_ext;
   logic signed [ACC_W-1:0] sum;
   logic [WIDTH-1:0]        result;
   logic                    dump;
   logic                    full;
   logic                    pop;
   logic                    push_ok;
   logic                    mem_we;

   assign data_ext = $signed({{DECIM_LOG2{data_i[WIDTH-1]}}, data_i});
   assign sum      = acc_reg + data_ext;
   // Dropping the low bits of the signed sum is a floor-rounded arithmetic shift.
   assign result   = sum[ACC_W-1:DECIM_LOG2];

   assign level_o   = wr_ptr_reg - rd_ptr_reg;
   assign valid_o   = (level_o != '0);
   assign full      = (level_o == FULL_LEVEL);
   assign overrun_o = overrun_reg;
   assign data_o    = mem_reg[rd_ptr_reg[FIFO_AW-1:0]];

   assign dump    = sample_vld_i && (cnt_reg == {DECIM_LOG2{1'b1}});
   assign pop     = valid_o && ready_i;
   assign push_ok = dump && (!full || pop);
   assign mem_we  = push_ok && !clear_i;

   always_comb begin
      acc_next     = acc_reg;
      cnt_next     = cnt_reg;
      wr_ptr_next  = wr_ptr_reg;
      rd_ptr_next  = rd_ptr_reg;
      overrun_next = overrun_reg;
      if (clear_i) begin
         acc_next     = '0;
         cnt_next     = '0;
         wr_ptr_next  = '0;
         rd_ptr_next  = '0;
         overrun_next = 1'b0;
      end else begin
         if (sample_vld_i) begin
            if (dump) begin
               acc_next = '0;
               cnt_next = '0;
            end else begin
               acc_next = sum;
               cnt_next = cnt_reg + 1'b1;
            end
         end
         if (push_ok)
            wr_ptr_next = wr_ptr_reg + 1'b1;
         if (pop)
            rd_ptr_next = rd_ptr_reg + 1'b1;
         if (dump && full && !pop)
            overrun_next = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_reg     <= '0;
         cnt_reg     <= '0;
         wr_ptr_reg  <= '0;
         rd_ptr_reg  <= '0;
         overrun_reg <= 1'b0;
      end else begin
         acc_reg     <= acc_next;
         cnt_reg     <= cnt_next;
         wr_ptr_reg  <= wr_ptr_next;
         rd_ptr_reg  <= rd_ptr_next;
         overrun_reg <= overrun_next;
      end
   end

   // Storage is cleared with the pointers so an empty FIFO's head reads zero.
   generate
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_mem
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)
               mem_reg[gi] <= '0;
            else if (clear_i)
               mem_reg[gi] <= '0;
            else if (mem_we && (wr_ptr_reg[FIFO_AW-1:0] == FIFO_AW'(gi)))
               mem_reg[gi] <= result;
         end
      end
   endgenerate

endmodule

// File: tb/tb_audio_decim_fifo.sv
// Directed bench for audio_decim_fifo at default parameters (decimate by 8, depth 4).
module tb_audio_decim_fifo;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        sample_vld_i;
   logic [15:0] data_i;
   logic        clear_i;
   logic [15:0] data_o;
   logic        valid_o;
   logic        ready_i;
   logic        overrun_o;
   logic [2:0]  level_o;

   int vectors = 0;
   int errs    = 0;

   audio_decim_fifo #(.WIDTH(16), .DECIM_LOG2(3), .FIFO_AW(2)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .sample_vld_i (sample_vld_i),
      .data_i       (data_i),
      .clear_i      (clear_i),
      .data_o       (data_o),
      .valid_o      (valid_o),
      .ready_i      (ready_i),
      .overrun_o    (overrun_o),
      .level_o      (level_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         errs++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Entered and left at 1 time unit after a rising edge.
   task automatic strobe(input logic [15:0] v);
      sample_vld_i = 1'b1;
      data_i       = v;
      @(posedge clk);
      #1;
      sample_vld_i = 1'b0;
      data_i       = 16'h0;
   endtask

   task automatic pop_one();
      ready_i = 1'b1;
      @(posedge clk);
      #1;
      ready_i = 1'b0;
   endtask

   task automatic idle();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n        = 1'b0;
      sample_vld_i = 1'b0;
      data_i       = 16'h0;
      clear_i      = 1'b0;
      ready_i      = 1'b0;
      #12;
      chk("rst_valid",   32'(valid_o),   0);
      chk("rst_level",   32'(level_o),   0);
      chk("rst_data",    32'(data_o),    0);
      chk("rst_overrun", 32'(overrun_o), 0);
      rst_n = 1'b1;
      idle();

      // Eight strobes of 100 with consumer ready
      ready_i = 1'b1;
      repeat (8) strobe(16'd100);
      chk("t1_valid", 32'(valid_o), 1);
      chk("t1_data",  32'(data_o),  32'(16'd100));
      chk("t1_level", 32'(level_o), 1);
      idle();
      chk("t1_level_after_pop", 32'(level_o), 0);
      chk("t1_valid_after_pop", 32'(valid_o), 0);
      ready_i = 1'b0;

      // Rounding cases
      for (int k = 1; k <= 8; k++) strobe(16'(k));
      chk("t2_ramp_pos", 32'(data_o), 32'(16'd4));
      pop_one();
      for (int k = 1; k <= 8; k++) strobe(16'(-k));
      chk("t2_ramp_neg", 32'(data_o), 32'(16'hFFFB));
      pop_one();
      repeat (8) strobe(16'hFFFF);
      chk("t2_minus_one", 32'(data_o), 32'(16'hFFFF));
      pop_one();
      chk("t2_level", 32'(level_o), 0);

      // Full-scale extremes
      repeat (8) strobe(16'h7FFF);
      chk("t3_max", 32'(data_o), 32'(16'h7FFF));
      pop_one();
      repeat (8) strobe(16'h8000);
      chk("t3_min", 32'(data_o), 32'(16'h8000));
      pop_one();

      // Overrun: five dumps into a four-entry FIFO with no consumer
      for (int d = 1; d <= 5; d++) begin
         repeat (8) strobe(16'(d));
         if (d == 4) begin
            chk("t4_level4",     32'(level_o),   4);
            chk("t4_no_overrun", 32'(overrun_o), 0);
         end
      end
      chk("t4_level_full", 32'(level_o),   4);
      chk("t4_overrun",    32'(overrun_o), 1);
      for (int d = 1; d <= 4; d++) begin
         chk($sformatf("t4_pop%0d", d), 32'(data_o), 32'(16'(d)));
         pop_one();
      end
      chk("t4_empty",          32'(valid_o),   0);
      chk("t4_overrun_sticky", 32'(overrun_o), 1);
      clear_i = 1'b1;
      idle();
      clear_i = 1'b0;
      chk("t4_overrun_cleared", 32'(overrun_o), 0);

      // Full FIFO, dump coincides with a pop
      for (int d = 1; d <= 4; d++) repeat (8) strobe(16'(10 * d));
      chk("t5_full", 32'(level_o), 4);
      repeat (7) strobe(16'd50);
      ready_i = 1'b1;
      strobe(16'd50);
      ready_i = 1'b0;
      chk("t5_level",   32'(level_o),   4);
      chk("t5_overrun", 32'(overrun_o), 0);
      for (int d = 2; d <= 5; d++) begin
         chk($sformatf("t5_pop%0d", d), 32'(data_o), 32'(16'(10 * d)));
         pop_one();
      end
      chk("t5_empty", 32'(level_o), 0);

      // Async reset mid-accumulation
      repeat (3) strobe(16'd1000);
      #3;
      rst_n = 1'b0;
      #1;
      chk("t6_rst_valid", 32'(valid_o), 0);
      chk("t6_rst_level", 32'(level_o), 0);
      chk("t6_rst_data",  32'(data_o),  0);
      #2;
      rst_n = 1'b1;
      idle();
      repeat (7) strobe(16'd8);
      chk("t6_no_early_dump", 32'(level_o), 0);
      strobe(16'd8);
      chk("t6_dump_level", 32'(level_o), 1);
      chk("t6_dump_data",  32'(data_o),  32'(16'd8));

      // Synchronous clear with a sample and a pop in the same cycle
      repeat (3) strobe(16'd1000);
      clear_i      = 1'b1;
      ready_i      = 1'b1;
      sample_vld_i = 1'b1;
      data_i       = 16'd1000;
      idle();
      clear_i      = 1'b0;
      ready_i      = 1'b0;
      sample_vld_i = 1'b0;
      chk("t6_clr_valid",   32'(valid_o),   0);
      chk("t6_clr_level",   32'(level_o),   0);
      chk("t6_clr_data",    32'(data_o),    0);
      chk("t6_clr_overrun", 32'(overrun_o), 0);
      repeat (7) strobe(16'd16);
      chk("t6_clr_no_early_dump", 32'(level_o), 0);
      strobe(16'd16);
      chk("t6_clr_dump_level", 32'(level_o), 1);
      chk("t6_clr_dump_data",  32'(data_o),  32'(16'd16));

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
      $finish;
   end

endmodule
